id_ex_stage_reg: RTL

- Pipeline register between the ID stage and the EX stage of the 5-stage MIPS core.
- In ID it captures the control unit's decoded outputs (alu_command, mem_read, mem_write, wb_enable, is_immediate) together with the register-file read data, the sign-extended immediate, the destination ID and the source IDs.
- It supports freeze (global memory stall), flush (kill), and bubble insertion (load-use hazard).
- It also keeps a saturating count of inserted bubbles for performance measurement.

---
 rtl/id_ex_stage_reg.sv | 107 ++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// It supports freeze, flush and bubble insertion, and keeps a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              bubble,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [3:0]        id_alu_command,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_wb_enable,
    input  logic              id_is_immediate,
    input  logic [DATA_W-1:0] id_reg1,
    input  logic [DATA_W-1:0] id_reg2,
    input  logic [15:0]       id_imm16,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [REG_W-1:0]  id_dest,
    output logic [DATA_W-1:0] ex_pc,
    output logic [3:0]        ex_alu_command,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_wb_enable,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_st_val,
    output logic [REG_W-1:0]  ex_src1,
    output logic [REG_W-1:0]  ex_src2,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [31:0]       sext32;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] next_val2;
    logic [REG_W-1:0]  next_src2;
    logic              load_nop;

    // The 32-bit sign extension is zero-padded when the datapath is wider than 32 bits.
    assign sext32    = {{16{id_imm16[15]}}, id_imm16};
    assign sext      = DATA_W'(sext32);
    assign next_val2 = id_is_immediate ? sext : id_reg2;
    assign next_src2 = id_is_immediate ? '0 : id_src2;
    assign load_nop  = flush | bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc          <= '0;
            ex_alu_command <= '0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_wb_enable   <= 1'b0;
            ex_val1        <= '0;
            ex_val2        <= '0;
            ex_st_val      <= '0;
            ex_src1        <= '0;
            ex_src2        <= '0;
            ex_dest        <= '0;
            ex_valid       <= 1'b0;
        end else if (!freeze) begin
            if (load_nop) begin
                ex_pc          <= '0;
                ex_alu_command <= '0;
                ex_mem_read    <= 1'b0;
                ex_mem_write   <= 1'b0;
                ex_wb_enable   <= 1'b0;
                ex_val1        <= '0;
                ex_val2        <= '0;
                ex_st_val      <= '0;
                ex_src1        <= '0;
                ex_src2        <= '0;
                ex_dest        <= '0;
                ex_valid       <= 1'b0;
            end else begin
                ex_pc          <= id_pc;
                ex_alu_command <= id_alu_command;
                ex_mem_read    <= id_mem_read;
                ex_mem_write   <= id_mem_write;
                ex_wb_enable   <= id_wb_enable;
                ex_val1        <= id_reg1;
                ex_val2        <= next_val2;
                ex_st_val      <= id_reg2;
                ex_src1        <= id_src1;
                ex_src2        <= next_src2;
                ex_dest        <= id_dest;
                ex_valid       <= 1'b1;
            end
        end
    end

    // A flush takes priority over a bubble, so only an unflushed bubble is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (!freeze && !flush && bubble && (bubble_count != '1)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule
